// File: rtl/axis_pkg.sv
// Shared definitions for the AXI-Stream sample source: sample width,
// output FSM state encoding and a pointer-width helper.
package axis_pkg;

  localparam int SAMPLE_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACE = 2'd1,
    SEND = 2'd2
  } state_t;

  // Address width for a FIFO of the given depth; never narrower than one bit.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/axis_sample_source_if.sv
// Sample write port plus AXI-Stream master port of axis_sample_source.
// master = the sample source itself, slave = the producer/FIR side.
interface axis_sample_source_if
  import axis_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
);

  localparam int LVL_W = ptr_w(DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_full;
  logic              m_axis_data_tvalid;
  logic [DATA_W-1:0] m_axis_data_tdata;
  logic              m_axis_data_tready;
  logic              overflow;
  logic [LVL_W-1:0]  level;

  modport master (
    input  in_valid, in_data, m_axis_data_tready,
    output in_full, m_axis_data_tvalid, m_axis_data_tdata, overflow, level
  );

  modport slave (
    output in_valid, in_data, m_axis_data_tready,
    input  in_full, m_axis_data_tvalid, m_axis_data_tdata, overflow, level
  );

endinterface

// File: rtl/sample_fifo.sv
// Power-of-two sample FIFO with registered count and full flag.
// A push on a full FIFO is still taken when a pop happens on the same edge.
module sample_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W,
  parameter int DEPTH  = 8
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_head,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [ptr_w(DEPTH):0]    o_count
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              r_full;
  logic              w_empty;
  logic              w_pop;
  logic              w_push;
  logic [CW-1:0]     w_count_nxt;

  assign w_empty     = (r_count == '0);
  assign w_pop       = i_pop && !w_empty;
  assign w_push      = i_push && (!r_full || w_pop);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Sample storage; contents are don't-care once the pointers are reset.
  always_ff @(posedge aclk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at DEPTH; count and full are registered together.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CW'(DEPTH));
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_empty = w_empty;
  assign o_full  = r_full;
  assign o_count = r_count;

endmodule

// File: rtl/axis_sample_source.sv
// Paced AXI-Stream sample source: FIFO-buffered samples are moved into an
// output register and offered to the FIR no more often than every RATE_DIV
// cycles. tvalid is a pure decode of the state register.
module axis_sample_source
  import axis_pkg::*;
#(
  parameter int DATA_W   = SAMPLE_W,
  parameter int DEPTH    = 8,
  parameter int RATE_DIV = 4
) (
  input  logic                  aclk,
  input  logic                  areset,
  axis_sample_source_if.master  bus
);

  localparam int          LVL_W     = ptr_w(DEPTH) + 1;
  localparam logic [15:0] PACE_LOAD = 16'(RATE_DIV - 1);

  state_t            r_state, w_state_nxt;
  logic [15:0]       r_pace, w_pace_nxt;
  logic [DATA_W-1:0] r_tdata;
  logic              r_overflow;
  logic              w_pop;
  logic              w_hs;
  logic              w_empty;
  logic              w_full;
  logic [DATA_W-1:0] w_head;
  logic [LVL_W-1:0]  w_count;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .aclk    (aclk),
    .areset  (areset),
    .i_push  (bus.in_valid),
    .i_data  (bus.in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  assign w_hs = (r_state == SEND) && bus.m_axis_data_tready;

  // Next state, pace counter and pop request; PACE leaves on the edge where
  // the counter reaches zero so handshakes land exactly RATE_DIV apart.
  always_comb begin
    w_state_nxt = r_state;
    w_pace_nxt  = r_pace;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty && r_pace == 16'd0) begin
          w_pop       = 1'b1;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_hs) begin
          w_pace_nxt = PACE_LOAD;
          if (PACE_LOAD != 16'd0) w_state_nxt = PACE;
          else if (!w_empty)      w_pop       = 1'b1;
          else                    w_state_nxt = IDLE;
        end
      end
      PACE: begin
        if (r_pace != 16'd0) w_pace_nxt = r_pace - 16'd1;
        if (r_pace <= 16'd1) begin
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = SEND;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, pace counter, output register and sticky drop flag.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state    <= IDLE;
      r_pace     <= 16'd0;
      r_tdata    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pace  <= w_pace_nxt;
      if (w_pop) r_tdata <= w_head;
      if (bus.in_valid && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  assign bus.m_axis_data_tvalid = (r_state == SEND);
  assign bus.m_axis_data_tdata  = r_tdata;
  assign bus.in_full            = w_full;
  assign bus.overflow           = r_overflow;
  assign bus.level              = w_count;

endmodule

// File: tb/tb_axis_sample_source.sv
// Directed bench for axis_sample_source: one instance with RATE_DIV=1 for
// streaming cases and one with RATE_DIV=4 for pacing, backpressure,
// overflow and reset cases. Both share clock and reset.
module tb_axis_sample_source;
  import axis_pkg::*;

  logic aclk = 1'b0;
  logic areset;

  always #5 aclk = ~aclk;

  axis_sample_source_if #(.DATA_W(16), .DEPTH(8)) bus1 ();
  axis_sample_source_if #(.DATA_W(16), .DEPTH(8)) bus4 ();

  axis_sample_source #(.DATA_W(16), .DEPTH(8), .RATE_DIV(1)) dut1 (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus1)
  );

  axis_sample_source #(.DATA_W(16), .DEPTH(8), .RATE_DIV(4)) dut4 (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus4)
  );

  typedef struct {
    logic        iv;
    logic [15:0] d;
    logic        tr;
    logic        ev;
    logic [15:0] ed;
    logic [3:0]  el;
  } vec_t;

  vec_t vecs [9];

  int n_chk = 0;
  int n_err = 0;

  int          hs_cyc [$];
  logic [15:0] hs_dat [$];
  int          hs_lvl [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Records handshakes on bus4 over a fixed number of cycles.
  task automatic collect_hs(input int ncyc);
    hs_cyc.delete();
    hs_dat.delete();
    hs_lvl.delete();
    for (int c = 0; c < ncyc; c++) begin
      if (bus4.m_axis_data_tvalid && bus4.m_axis_data_tready) begin
        hs_cyc.push_back(c);
        hs_dat.push_back(bus4.m_axis_data_tdata);
        hs_lvl.push_back(int'(bus4.level));
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 16'h0001, 1'b0, 1'b0, 16'h0000, 4'd1};
    vecs[1] = '{1'b1, 16'h0002, 1'b0, 1'b1, 16'h0001, 4'd1};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0001, 4'd1};
    vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h0002, 4'd0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 4'd0};
    vecs[5] = '{1'b1, 16'hFFFF, 1'b1, 1'b0, 16'h0002, 4'd1};
    vecs[6] = '{1'b1, 16'h8001, 1'b1, 1'b1, 16'hFFFF, 4'd1};
    vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 16'h8001, 4'd0};
    vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h8001, 4'd0};

    areset = 1'b1;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.m_axis_data_tready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_data = '0; bus4.m_axis_data_tready = 1'b0;
    repeat (2) tick();

    // Reset values
    chk("rst_tvalid1", 32'(bus1.m_axis_data_tvalid), 0);
    chk("rst_tdata1",  32'(bus1.m_axis_data_tdata), 0);
    chk("rst_level1",  32'(bus1.level), 0);
    chk("rst_full1",   32'(bus1.in_full), 0);
    chk("rst_ovf1",    32'(bus1.overflow), 0);
    chk("rst_tvalid4", 32'(bus4.m_axis_data_tvalid), 0);
    chk("rst_level4",  32'(bus4.level), 0);
    areset = 1'b0;

    // Table vectors on the RATE_DIV=1 instance; first write lands on the
    // first edge after reset release.
    for (int i = 0; i < 9; i++) begin
      bus1.in_valid = vecs[i].iv;
      bus1.in_data  = vecs[i].d;
      bus1.m_axis_data_tready = vecs[i].tr;
      tick();
      chk($sformatf("vec%0d_tvalid", i), 32'(bus1.m_axis_data_tvalid), 32'(vecs[i].ev));
      chk($sformatf("vec%0d_tdata", i),  32'(bus1.m_axis_data_tdata),  32'(vecs[i].ed));
      chk($sformatf("vec%0d_level", i),  32'(bus1.level),              32'(vecs[i].el));
    end
    bus1.in_valid = 1'b0;
    bus1.m_axis_data_tready = 1'b0;
    tick();

    // Back-to-back streaming, RATE_DIV=1
    bus1.m_axis_data_tready = 1'b1;
    bus1.in_valid = 1'b1; bus1.in_data = 16'h0001;
    tick();
    chk("b2b_lat_tvalid", 32'(bus1.m_axis_data_tvalid), 0);
    bus1.in_data = 16'h0002;
    tick();
    chk("b2b_s1", 32'({bus1.m_axis_data_tvalid, bus1.m_axis_data_tdata}), 32'h1_0001);
    bus1.in_data = 16'h0003;
    tick();
    chk("b2b_s2", 32'({bus1.m_axis_data_tvalid, bus1.m_axis_data_tdata}), 32'h1_0002);
    bus1.in_valid = 1'b0;
    tick();
    chk("b2b_s3", 32'({bus1.m_axis_data_tvalid, bus1.m_axis_data_tdata}), 32'h1_0003);
    tick();
    chk("b2b_end_tvalid", 32'(bus1.m_axis_data_tvalid), 0);

    // Simultaneous write and pop on a full FIFO, RATE_DIV=1
    bus1.m_axis_data_tready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = 16'h0100 + 16'(i);
      tick();
    end
    chk("sim_pre_level", 32'(bus1.level), 8);
    chk("sim_pre_full",  32'(bus1.in_full), 1);
    chk("sim_pre_tdata", 32'(bus1.m_axis_data_tdata), 32'h0100);
    bus1.in_data = 16'h0200;
    bus1.m_axis_data_tready = 1'b1;
    tick();
    chk("sim_level", 32'(bus1.level), 8);
    chk("sim_full",  32'(bus1.in_full), 1);
    chk("sim_ovf",   32'(bus1.overflow), 0);
    chk("sim_tdata", 32'(bus1.m_axis_data_tdata), 32'h0101);
    bus1.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("sim_drain%0d", k),
          32'({bus1.m_axis_data_tvalid, bus1.m_axis_data_tdata}),
          (k < 7) ? (32'h1_0102 + 32'(k)) : 32'h1_0200);
    end
    tick();
    chk("sim_end_tvalid", 32'(bus1.m_axis_data_tvalid), 0);
    chk("sim_end_level",  32'(bus1.level), 0);
    bus1.m_axis_data_tready = 1'b0;

    // Pacing, RATE_DIV=4: one sample in the output register, five queued
    bus4.m_axis_data_tready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 16'h0A00 + 16'(i);
      tick();
    end
    bus4.in_valid = 1'b0;
    chk("pace_pre_level", 32'(bus4.level), 5);
    bus4.m_axis_data_tready = 1'b1;
    collect_hs(40);
    chk("pace_count", 32'(hs_cyc.size()), 6);
    for (int k = 0; k < hs_cyc.size() && k < 6; k++) begin
      chk($sformatf("pace_data%0d", k), 32'(hs_dat[k]), 32'h0A00 + 32'(k));
      chk($sformatf("pace_level%0d", k), 32'(hs_lvl[k]), 32'(5 - k));
      if (k > 0) chk($sformatf("pace_gap%0d", k), 32'(hs_cyc[k] - hs_cyc[k-1]), 4);
    end

    // Backpressure: sample held while tready is low
    bus4.m_axis_data_tready = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_data = 16'h8000;
    tick();
    bus4.in_valid = 1'b0;
    tick();
    chk("bp_first", 32'({bus4.m_axis_data_tvalid, bus4.m_axis_data_tdata}), 32'h1_8000);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("bp_hold%0d", c),
          32'({bus4.m_axis_data_tvalid, bus4.m_axis_data_tdata}), 32'h1_8000);
    end
    bus4.m_axis_data_tready = 1'b1;
    collect_hs(10);
    chk("bp_hs_count", 32'(hs_cyc.size()), 1);
    if (hs_dat.size() > 0) chk("bp_hs_data", 32'(hs_dat[0]), 32'h8000);

    // Overflow: ten writes with tready low, last one dropped
    bus4.m_axis_data_tready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 16'h0010 + 16'(i);
      tick();
      if (i == 0) chk("ovf_w0_level", 32'(bus4.level), 1);
      if (i == 8) begin
        chk("ovf_w8_level", 32'(bus4.level), 8);
        chk("ovf_w8_full",  32'(bus4.in_full), 1);
        chk("ovf_w8_ovf",   32'(bus4.overflow), 0);
      end
      if (i == 9) begin
        chk("ovf_w9_level", 32'(bus4.level), 8);
        chk("ovf_w9_full",  32'(bus4.in_full), 1);
        chk("ovf_w9_ovf",   32'(bus4.overflow), 1);
      end
    end
    bus4.in_valid = 1'b0;
    bus4.m_axis_data_tready = 1'b1;
    collect_hs(60);
    chk("ovf_drain_count", 32'(hs_cyc.size()), 9);
    for (int k = 0; k < hs_dat.size() && k < 9; k++)
      chk($sformatf("ovf_drain%0d", k), 32'(hs_dat[k]), 32'h0010 + 32'(k));
    chk("ovf_sticky", 32'(bus4.overflow), 1);
    chk("ovf_end_level", 32'(bus4.level), 0);
    chk("ovf_end_full",  32'(bus4.in_full), 0);

    // Reset in the middle of SEND with three samples queued
    bus4.m_axis_data_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 16'h0300 + 16'(i);
      tick();
    end
    bus4.in_valid = 1'b0;
    chk("mid_pre_level",  32'(bus4.level), 3);
    chk("mid_pre_tvalid", 32'(bus4.m_axis_data_tvalid), 1);
    areset = 1'b1;
    #1;
    chk("mid_rst_tvalid", 32'(bus4.m_axis_data_tvalid), 0);
    chk("mid_rst_level",  32'(bus4.level), 0);
    chk("mid_rst_tdata",  32'(bus4.m_axis_data_tdata), 0);
    chk("mid_rst_ovf",    32'(bus4.overflow), 0);
    tick();
    areset = 1'b0;
    bus4.in_valid = 1'b1; bus4.in_data = 16'h7FFF;
    tick();
    bus4.in_valid = 1'b0;
    chk("mid_w_level",  32'(bus4.level), 1);
    chk("mid_w_tvalid", 32'(bus4.m_axis_data_tvalid), 0);
    tick();
    chk("mid_out", 32'({bus4.m_axis_data_tvalid, bus4.m_axis_data_tdata}), 32'h1_7FFF);
    chk("mid_out_level", 32'(bus4.level), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
